// File: rtl/mem_arbiter_if.sv
// Bundles the two requester ports and the single-port mem bus of mem_arbiter.
// slave is the arbiter side; master is the requesters-plus-memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0, lock0, wr_en0, ack0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] data_in0, data_out0;

  logic              req1, lock1, wr_en1, ack1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] data_in1, data_out1;

  logic              wr_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_out, data_in;

  logic              busy, timeout;

  modport slave (
    input  req0, lock0, wr_en0, addr0, data_in0,
    output data_out0, ack0,
    input  req1, lock1, wr_en1, addr1, data_in1,
    output data_out1, ack1,
    output wr_en, addr, data_out,
    input  data_in,
    output busy, timeout
  );

  modport master (
    output req0, lock0, wr_en0, addr0, data_in0,
    input  data_out0, ack0,
    output req1, lock1, wr_en1, addr1, data_in1,
    input  data_out1, ack1,
    input  wr_en, addr, data_out,
    output data_in,
    input  busy, timeout
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter for a single-port mem: IDLE -> ACC -> RESP.
// Define ARB_TIMEOUT_EN to break a held lock after LOCK_MAX consecutive grants.
module mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic          clk,
  input  logic          nrst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  state_t state, state_nxt;
  cmd_t   cmd, cmd_nxt;
  logic   last, g;
  logic   grant, win, relock, brk, lk_max;

  logic [1:0]             req, lock, wr_in;
  logic [1:0][ADDR_W-1:0] addr_in;
  logic [1:0][DATA_W-1:0] wdata_in;
  logic [1:0][DATA_W-1:0] rd_q;

  assign req      = {bus.req1, bus.req0};
  assign lock     = {bus.lock1, bus.lock0};
  assign wr_in    = {bus.wr_en1, bus.wr_en0};
  assign addr_in  = {bus.addr1, bus.addr0};
  assign wdata_in = {bus.data_in1, bus.data_in0};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      last  <= 1'b1;
      g     <= 1'b0;
      cmd   <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        g    <= win;
        last <= win;
        cmd  <= cmd_nxt;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_nxt   = cmd;
    grant     = 1'b0;
    win       = g;
    relock    = 1'b0;
    brk       = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          grant = 1'b1;
          win   = (req == 2'b11) ? ~last : req[1];
        end
      end
      ACC: state_nxt = RESP;
      RESP: begin
        // A locked owner keeps the port unless its lock budget is spent and the other side waits.
        if (req[g] && lock[g] && !(lk_max && req[~g])) begin
          grant  = 1'b1;
          win    = g;
          relock = 1'b1;
        end else if (req[~g]) begin
          grant = 1'b1;
          win   = ~g;
          brk   = req[g] && lock[g];
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (grant) begin
      state_nxt    = ACC;
      cmd_nxt.wr   = wr_in[win];
      cmd_nxt.addr = addr_in[win];
      cmd_nxt.data = wdata_in[win];
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  logic [CNT_W-1:0] lk_cnt;

  assign lk_max = (lk_cnt == CNT_W'(LOCK_MAX - 1));

  // Saturates so a long solo lock still yields as soon as the other side asks.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)      lk_cnt <= '0;
    else if (grant) lk_cnt <= relock ? (lk_max ? lk_cnt : lk_cnt + 1'b1) : '0;
  end
`else
  logic unused_cfg;
  assign lk_max     = 1'b0;
  assign unused_cfg = (LOCK_MAX != 0) ^ relock;
`endif

  // Read data is captured at the edge that closes ACC; writes leave it alone.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_q <= '0;
    end else if (state == ACC && !cmd.wr) begin
      for (int i = 0; i < 2; i++)
        if (g == 1'(i)) rd_q[i] <= bus.data_in;
    end
  end

  assign bus.wr_en     = (state == ACC) && cmd.wr;
  assign bus.addr      = cmd.addr;
  assign bus.data_out  = cmd.data;
  assign bus.ack0      = (state == RESP) && !g;
  assign bus.ack1      = (state == RESP) && g;
  assign bus.data_out0 = rd_q[0];
  assign bus.data_out1 = rd_q[1];
  assign bus.busy      = (state != IDLE);
  assign bus.timeout   = brk;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-array mem model and an ack scoreboard.
// Build with ARB_TIMEOUT_EN to exercise the lock-break path.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LOCK_MAX(4)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    bit          wr;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  logic [31:0] ref_mem [int];
  logic [31:0] last_rd [2];
  logic [7:0]  mem [0:255];

  // Combinational-read, write-on-edge memory, little-endian bytes.
  assign bus.data_in = {mem[bus.addr[7:0] + 8'd3], mem[bus.addr[7:0] + 8'd2],
                        mem[bus.addr[7:0] + 8'd1], mem[bus.addr[7:0]]};

  always @(posedge clk)
    if (bus.wr_en)
      for (int b = 0; b < 4; b++) mem[bus.addr[7:0] + 8'(b)] <= bus.data_out[8*b +: 8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [7:0] a);
    return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
  endfunction

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    for (int b = 0; b < 4; b++) mem[a + 8'(b)] = d[8*b +: 8];
    ref_mem[int'(a)] = d;
  endtask

  task automatic drive(input int id, input bit rq, input bit lk, input bit wr,
                       input logic [31:0] a, input logic [31:0] d);
    if (id == 0) begin
      bus.req0 = rq; bus.lock0 = lk; bus.wr_en0 = wr; bus.addr0 = a; bus.data_in0 = d;
    end else begin
      bus.req1 = rq; bus.lock1 = lk; bus.wr_en1 = wr; bus.addr1 = a; bus.data_in1 = d;
    end
  endtask

  task automatic push(input int id, input bit wr, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    if (wr) ref_mem[int'(a)] = d;
    e.id   = id;
    e.wr   = wr;
    e.data = ref_mem[int'(a)];
    q.push_back(e);
  endtask

  task automatic wait_ack(input int id, input int max, output int n);
    logic a;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      a = (id == 0) ? bus.ack0 : bus.ack1;
    end while (!a && n < max);
    chk($sformatf("ack%0d_seen", id), 32'(a), 32'd1);
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_ctl"},  32'({bus.wr_en, bus.busy, bus.ack0, bus.ack1, bus.timeout}), 32'd0);
    chk({tag, "_addr"}, bus.addr, 32'd0);
    chk({tag, "_wdat"}, bus.data_out, 32'd0);
    chk({tag, "_rd0"},  bus.data_out0, 32'd0);
    chk({tag, "_rd1"},  bus.data_out1, 32'd0);
  endtask

  task automatic issue(input int id, input int c, input bit wr);
    logic [31:0] a, d;
    a = 32'((c % 4) * 4);
    d = $urandom;
    drive(id, 1'b1, 1'b0, wr, a, d);
    push(id, wr, a, d);
  endtask

  // Both requesters keep req up and reload a new command on each of their acks.
  task automatic stream(input bit wr);
    int j0, j1, done, cyc;
    j0 = 1; j1 = 1; done = 0; cyc = 0;
    issue(0, 0, wr);
    issue(1, 1, wr);
    while (done < 16 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.ack0) begin
        done++;
        if (j0 < 8) begin issue(0, 2*j0, wr); j0++; end
        else drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      end
      if (bus.ack1) begin
        done++;
        if (j1 < 8) begin issue(1, 2*j1 + 1, wr); j1++; end
        else drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      end
    end
    chk(wr ? "stream_wr_done" : "stream_rd_done", 32'(done), 32'd16);
    @(negedge clk);
  endtask

  // Scoreboard: every ack is matched against the oldest expected access.
  always @(negedge clk) begin
    int   id;
    exp_t e;
    if (!nrst) begin
      last_rd[0] = '0;
      last_rd[1] = '0;
    end else begin
      if (bus.wr_en) chk("wr_en_only_in_acc", 32'({bus.busy, bus.ack0 | bus.ack1}), 32'd2);
      chk("ack_exclusive", 32'(bus.ack0 & bus.ack1), 32'd0);
`ifndef ARB_TIMEOUT_EN
      chk("timeout_tied", 32'(bus.timeout), 32'd0);
`endif
      if (bus.ack0 || bus.ack1) begin
        id = bus.ack1 ? 1 : 0;
        chk("ack_expected", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("ack_id", 32'(id), 32'(e.id));
          if (e.wr) begin
            chk("wr_keeps_rd", id ? bus.data_out1 : bus.data_out0, last_rd[id]);
          end else begin
            chk("rd_data", id ? bus.data_out1 : bus.data_out0, e.data);
            last_rd[id] = e.data;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nlk;
    drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    preload(8'h00, 32'h11223344);
    preload(8'h04, 32'hA5A5A5A5);
    preload(8'h08, 32'h0BADF00D);
    preload(8'h0C, 32'h5A5A0000);

    #1 chk_outs_zero("reset");
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    // Reset lands in the middle of a write access.
    drive(0, 1'b1, 1'b0, 1'b1, 32'h4, 32'h12345678);
    @(negedge clk);
    chk("acc_wr_en", 32'(bus.wr_en), 32'd1);
    chk("acc_addr", bus.addr, 32'h4);
    chk("acc_busy", 32'(bus.busy), 32'd1);
    #1 nrst = 1'b0;
    #1 chk_outs_zero("mid_acc_rst");
    drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    chk("rst_no_write", rd_mem(8'h04), 32'hA5A5A5A5);
    nrst = 1'b1;
    @(negedge clk);

    // Single write then read by requester 0.
    drive(0, 1'b1, 1'b0, 1'b1, 32'h8, 32'hDEADBEEF);
    push(0, 1'b1, 32'h8, 32'hDEADBEEF);
    wait_ack(0, 10, n);
    chk("wr_latency", 32'(n), 32'd2);
    drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 1'b0, 32'h8, 32'd0);
    push(0, 1'b0, 32'h8, 32'd0);
    wait_ack(0, 10, n);
    chk("rd_latency", 32'(n), 32'd2);
    chk("rd_data0", bus.data_out0, 32'hDEADBEEF);
    drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);

    // Tie right after reset: 0 first, then 1, then 0 again.
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      drive(0, 1'b1, 1'b0, 1'b0, r ? 32'h4 : 32'h0, 32'd0);
      drive(1, 1'b1, 1'b0, 1'b0, r ? 32'hC : 32'h8, 32'd0);
      push(0, 1'b0, r ? 32'h4 : 32'h0, 32'd0);
      push(1, 1'b0, r ? 32'hC : 32'h8, 32'd0);
      wait_ack(0, 10, n);
      chk("tie_first0", 32'(n), 32'd2);
      chk("tie_no_ack1", 32'(bus.ack1), 32'd0);
      drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      wait_ack(1, 10, n);
      chk("tie_then1", 32'(n), 32'd2);
      drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
    end

    // Locked read-modify-write holds off a pending requester 1.
    drive(0, 1'b1, 1'b1, 1'b0, 32'h0, 32'd0);
    drive(1, 1'b1, 1'b0, 1'b1, 32'hC, 32'hCAFE0001);
    push(0, 1'b0, 32'h0, 32'd0);
    push(0, 1'b1, 32'h0, 32'h11223345);
    push(1, 1'b1, 32'hC, 32'hCAFE0001);
    wait_ack(0, 10, n);
    chk("rmw_rd_lat", 32'(n), 32'd2);
    chk("rmw_rd_val", bus.data_out0, 32'h11223344);
    drive(0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h11223345);
    wait_ack(0, 10, n);
    chk("rmw_back2back", 32'(n), 32'd2);
    drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_ack(1, 10, n);
    chk("rmw_then1", 32'(n), 32'd2);
    drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'd0);
    push(0, 1'b0, 32'h0, 32'd0);
    wait_ack(0, 10, n);
    chk("rmw_final", bus.data_out0, 32'h11223345);
    drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);

    // Requester 0 holds lock while requester 1 waits.
`ifdef ARB_TIMEOUT_EN
    nlk = 4;
`else
    nlk = 10;
`endif
    for (int k = 0; k < nlk; k++) push(0, 1'b0, 32'h8, 32'd0);
    push(1, 1'b0, 32'hC, 32'd0);
    drive(0, 1'b1, 1'b1, 1'b0, 32'h8, 32'd0);
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 1'b0, 32'hC, 32'd0);
    for (int k = 0; k < nlk; k++) begin
      wait_ack(0, 10, n);
      chk("lock_period", 32'(n), (k == 0) ? 32'd1 : 32'd2);
`ifdef ARB_TIMEOUT_EN
      chk("lock_timeout", 32'(bus.timeout), (k == nlk - 1) ? 32'd1 : 32'd0);
`else
      chk("lock_timeout", 32'(bus.timeout), 32'd0);
      if (k == nlk - 1) drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
`endif
    end
`ifdef ARB_TIMEOUT_EN
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_ack(1, 10, n);
    chk("starve_ack1", 32'(n), 32'd1);
`else
    wait_ack(1, 10, n);
    chk("starve_ack1", 32'(n), 32'd2);
`endif
    chk("starve_timeout_end", 32'(bus.timeout), 32'd0);
    drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);

    // Interleaved write stream from both requesters, then read it back.
    stream(1'b1);
    stream(1'b0);

    chk("queue_empty", 32'(q.size()), 32'd0);
    chk("idle_at_end", 32'(bus.busy), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester round-robin arbiter sharing the single-port `mem` block between two sequencers (e.g. two `fsm`-style masters).
- Latches one requester's command, drives the mem port for exactly one access cycle, then returns an ack plus registered read data.
- A lock input lets the owner chain back-to-back accesses (read-modify-write) without losing the port.

Parameters:
- ADDR_W, 32, address width passed unchanged to mem (byte address, word = addr..addr+3).
- DATA_W, 32, data width.
- LOCK_MAX, 8, max consecutive locked grants to one requester (used only with ARB_TIMEOUT_EN).

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  reset, asynchronous, active-low.
- req0  in  1  requester 0 request (level, held until ack0).
- lock0  in  1  requester 0 keep-grant after ack.
- wr_en0  in  1  requester 0 write(1)/read(0).
- addr0  in  ADDR_W  requester 0 address.
- data_in0  in  DATA_W  requester 0 write data.
- data_out0  out  DATA_W  read data to requester 0, valid while ack0=1.
- ack0  out  1  one-cycle completion pulse to requester 0.
- req1, lock1, wr_en1, addr1, data_in1, data_out1, ack1: same for requester 1.
- wr_en  out  1  to mem write enable.
- addr  out  ADDR_W  to mem address.
- data_out  out  DATA_W  to mem write data.
- data_in  in  DATA_W  from mem read data (combinational read of addr).
- busy  out  1  high in ACC and RESP.
- timeout  out  1  one-cycle pulse when lock forcibly broken (0 without macro).

Behaviour:
- Reset (nrst=0, async): state=IDLE, last=1; all outputs 0, including wr_en, addr, data_out, data_out0/1, ack0/1, busy, timeout. Latched cmd regs=0.
- Reset mid-ACC drops wr_en at once; no write occurs. Reset in RESP aborts the ack.
- States: IDLE, ACC, RESP.
- Arbitration, evaluated in IDLE and in RESP:
  - One requester asserts req: it wins.
  - Both assert req: the one not equal to `last` wins.
  - The winner's wr_en/addr/data_in are latched into cmd regs, g <= winner, last <= winner, then go to ACC.
- ACC (1 cycle):
  - mem port driven from cmd regs; wr_en=latched wr.
  - mem write happens at the edge ending ACC; data_in is sampled into data_out<g> at that same edge (reads only; writes leave data_out<g> unchanged).
  - Next state RESP.
- RESP (1 cycle):
  - ack<g>=1; mem wr_en=0 (addr/data_out hold).
  - The served requester's req is ignored unless lock<g>=1 and req<g>=1; in that case it is re-granted (latch, ACC) regardless of the other request.
  - Otherwise, if the other requester has req, grant it, else go to IDLE.
- Latency: req high at edge N in IDLE -> ACC in cycle N+1 -> ack in cycle N+2. Back-to-back locked accesses take 2 cycles each.
- Requester protocol:
  - Hold req and command stable until the edge where ack is seen, then drop req or keep it with lock for the next access.
  - Command change while req is high before ack: the latched value is used; later changes are ignored.
- data_out0/1 hold their last read value until the next read for that requester.
- ack0 and ack1 are never high together; mem wr_en is high only in ACC.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - Counter lk_cnt increments on each locked re-grant and clears on any non-locked grant.
  - When lk_cnt==LOCK_MAX-1 and the other requester has req, lock is ignored: the other requester is granted, timeout pulses 1 cycle in that RESP, and lk_cnt clears.
- Not defined: no counter; lock honoured indefinitely; timeout tied 0.

Test Plan:
- Reset: nrst=0 mid-ACC with wr_en0=1 to addr 0x4 -> wr_en drops immediately, mem[4..7] unchanged, all outputs 0.
- Single write/read: req0 writes 0xDEADBEEF to addr 0x8, then reads 0x8 -> ack0 at cycle N+2 both times, data_out0=0xDEADBEEF, ack1 never asserts.
- Tie after reset: req0 and req1 both high at the same edge -> requester 0 served first, requester 1 next; ack0 then ack1 two cycles apart; then tie again -> requester 0 (alternation).
- Lock RMW: req0+lock0 reads 0x0 (0x11223344), writes 0x11223345 while req1 is pending -> requester 1 granted only after the unlocked access; final read returns 0x11223345.
- Lock starvation, ARB_TIMEOUT_EN, LOCK_MAX=4: req0+lock0 held continuously, req1 high -> requester 1 acked after 4 requester-0 accesses, timeout pulses once; without the macro requester 1 is never acked while lock0 is held.
- Stream: both requesters issue 16 alternating writes over addr 0x0-0xC then read back -> all data match, no cycle with wr_en=1 outside ACC.
